// File: rtl/median_window_gen_if.sv
// Sample-stream and window-output bundle between the line source, the
// window generator and the downstream 3-tap median filter.
interface median_window_gen_if #(
  parameter int DATA_W = 8
);

  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              hold_i;
  logic              ready_o;
  logic              en_o;
  logic [DATA_W-1:0] d1_o;
  logic [DATA_W-1:0] d2_o;
  logic [DATA_W-1:0] d3_o;
  logic              last_o;

  // Source side: drives samples and the downstream stall, observes windows.
  modport master (
    output valid_i, data_i, hold_i,
    input  ready_o, en_o, d1_o, d2_o, d3_o, last_o
  );

  // Window generator side.
  modport slave (
    input  valid_i, data_i, hold_i,
    output ready_o, en_o, d1_o, d2_o, d3_o, last_o
  );

endinterface

// File: rtl/median_window_gen.sv
// Sliding 3-sample window generator with edge replication at both ends of
// each fixed-length line. One window per accepted sample; the last window of
// a line is issued from a one-cycle FLUSH bubble that takes no input.
// LINE_LEN must be at least 2.
module median_window_gen #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  median_window_gen_if.slave  bus
);

  localparam int CNT_W = $clog2(LINE_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    FLUSH
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   older_q, older_d;
  logic [DATA_W-1:0]   newer_q, newer_d;
  logic [DATA_W-1:0]   d1_q, d1_d;
  logic [DATA_W-1:0]   d2_q, d2_d;
  logic [DATA_W-1:0]   d3_q, d3_d;
  logic                en_q, en_d;
  logic                last_q, last_d;

  logic                ready;
  logic                accept;

  assign ready  = !bus.hold_i && (state_q != FLUSH);
  assign accept = bus.valid_i && ready;

  assign bus.ready_o = ready;
  assign bus.en_o    = en_q;
  assign bus.last_o  = last_q;
  assign bus.d1_o    = d1_q;
  assign bus.d2_o    = d2_q;
  assign bus.d3_o    = d3_q;

  // Next-state, history shift and window issue; outputs hold unless a window is issued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    older_d = older_q;
    newer_d = newer_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    en_d    = 1'b0;
    last_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          newer_d = bus.data_i;
          cnt_d   = CNT_W'(1);
          state_d = PRIME;
        end
      end

      PRIME: begin
        if (accept) begin
          d1_d    = newer_q;
          d2_d    = newer_q;
          d3_d    = bus.data_i;
          en_d    = 1'b1;
          older_d = newer_q;
          newer_d = bus.data_i;
          cnt_d   = CNT_W'(2);
          state_d = (LINE_LEN == 2) ? FLUSH : RUN;
        end
      end

      RUN: begin
        if (accept) begin
          d1_d    = older_q;
          d2_d    = newer_q;
          d3_d    = bus.data_i;
          en_d    = 1'b1;
          older_d = newer_q;
          newer_d = bus.data_i;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LINE_LEN - 1)) begin
            state_d = FLUSH;
          end
        end
      end

      FLUSH: begin
        if (!bus.hold_i) begin
          d1_d    = older_q;
          d2_d    = newer_q;
          d3_d    = newer_q;
          en_d    = 1'b1;
          last_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, history and output registers; reset discards any partial line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      older_q <= '0;
      newer_q <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      en_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      older_q <= older_d;
      newer_q <= newer_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      en_q    <= en_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_median_window_gen.sv
// Directed bench for median_window_gen: one LINE_LEN=4 instance and one
// LINE_LEN=2 instance, inputs changed 1 ns after each rising edge and
// outputs sampled at the same point.
module tb_median_window_gen;

  localparam int DW = 8;

  logic clk;
  logic rst_n;

  int vectors;
  int misses;

  median_window_gen_if #(.DATA_W(DW)) bus4 ();
  median_window_gen_if #(.DATA_W(DW)) bus2 ();

  median_window_gen #(.DATA_W(DW), .LINE_LEN(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  median_window_gen #(.DATA_W(DW), .LINE_LEN(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic h);
    bus4.valid_i = v;
    bus4.data_i  = d;
    bus4.hold_i  = h;
  endtask

  task automatic applyStimulus2(input logic v, input logic [DW-1:0] d, input logic h);
    bus2.valid_i = v;
    bus2.data_i  = d;
    bus2.hold_i  = h;
  endtask

  task automatic checkOutput(input string tag, input logic [3*DW+1:0] obs,
                             input logic [3*DW+1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkWin4(input string tag, input logic en, input logic last,
                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c);
    checkOutput(tag, {bus4.en_o, bus4.last_o, bus4.d1_o, bus4.d2_o, bus4.d3_o},
                {en, last, a, b, c});
  endtask

  task automatic checkWin2(input string tag, input logic en, input logic last,
                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c);
    checkOutput(tag, {bus2.en_o, bus2.last_o, bus2.d1_o, bus2.d2_o, bus2.d3_o},
                {en, last, a, b, c});
  endtask

  task automatic checkReady(input string tag, input logic obs, input logic exp);
    checkOutput(tag, {{(3*DW+1){1'b0}}, obs}, {{(3*DW+1){1'b0}}, exp});
  endtask

  // Directed sequence.
  initial begin
    vectors = 0;
    misses  = 0;
    rst_n   = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0);
    applyStimulus2(1'b0, 8'd0, 1'b0);
    tick();

    $display("[TB] reset state");
    checkWin4("rst_win4", 0, 0, 0, 0, 0);
    checkWin2("rst_win2", 0, 0, 0, 0, 0);
    checkReady("rst_ready", bus4.ready_o, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1);
    #1;
    checkReady("rst_ready_hold", bus4.ready_o, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0);
    rst_n = 1'b1;

    $display("[TB] contiguous line 10..40");
    applyStimulus(1, 8'd10, 0); tick(); checkWin4("c_x0", 0, 0, 0, 0, 0);
    applyStimulus(1, 8'd20, 0); tick(); checkWin4("c_w0", 1, 0, 10, 10, 20);
    applyStimulus(1, 8'd30, 0); tick(); checkWin4("c_w1", 1, 0, 10, 20, 30);
    checkReady("c_ready_run", bus4.ready_o, 1'b1);
    applyStimulus(1, 8'd40, 0); tick(); checkWin4("c_w2", 1, 0, 20, 30, 40);
    checkReady("c_ready_flush", bus4.ready_o, 1'b0);
    applyStimulus(0, 8'd0, 0); tick(); checkWin4("c_w3", 1, 1, 30, 40, 40);
    checkReady("c_ready_idle", bus4.ready_o, 1'b1);
    tick(); checkWin4("c_hold", 0, 0, 30, 40, 40);

    $display("[TB] back-to-back lines");
    applyStimulus(1, 8'd1, 0); tick(); checkWin4("b_x0", 0, 0, 30, 40, 40);
    applyStimulus(1, 8'd2, 0); tick(); checkWin4("b_w0", 1, 0, 1, 1, 2);
    applyStimulus(1, 8'd3, 0); tick(); checkWin4("b_w1", 1, 0, 1, 2, 3);
    applyStimulus(1, 8'd4, 0); tick(); checkWin4("b_w2", 1, 0, 2, 3, 4);
    applyStimulus(1, 8'd99, 0); tick(); checkWin4("b_w3", 1, 1, 3, 4, 4);
    applyStimulus(1, 8'd5, 0); tick(); checkWin4("b_x4", 0, 0, 3, 4, 4);
    applyStimulus(1, 8'd6, 0); tick(); checkWin4("b_w4", 1, 0, 5, 5, 6);
    applyStimulus(1, 8'd7, 0); tick(); checkWin4("b_w5", 1, 0, 5, 6, 7);
    applyStimulus(1, 8'd8, 0); tick(); checkWin4("b_w6", 1, 0, 6, 7, 8);
    applyStimulus(0, 8'd0, 0); tick(); checkWin4("b_w7", 1, 1, 7, 8, 8);

    $display("[TB] valid gap");
    applyStimulus(1, 8'd10, 0); tick(); checkWin4("g_x0", 0, 0, 7, 8, 8);
    applyStimulus(1, 8'd20, 0); tick(); checkWin4("g_w0", 1, 0, 10, 10, 20);
    applyStimulus(0, 8'd55, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); checkWin4("g_gap", 0, 0, 10, 10, 20);
    end
    applyStimulus(1, 8'd30, 0); tick(); checkWin4("g_w1", 1, 0, 10, 20, 30);
    applyStimulus(1, 8'd40, 0); tick(); checkWin4("g_w2", 1, 0, 20, 30, 40);
    applyStimulus(0, 8'd0, 0); tick(); checkWin4("g_w3", 1, 1, 30, 40, 40);

    $display("[TB] hold during flush");
    applyStimulus(1, 8'd10, 0); tick();
    applyStimulus(1, 8'd20, 0); tick();
    applyStimulus(1, 8'd30, 0); tick();
    applyStimulus(1, 8'd40, 0); tick(); checkWin4("h_w2", 1, 0, 20, 30, 40);
    applyStimulus(1, 8'd77, 1);
    #1;
    checkReady("h_ready0", bus4.ready_o, 1'b0);
    tick(); checkWin4("h_held0", 0, 0, 20, 30, 40);
    checkReady("h_ready1", bus4.ready_o, 1'b0);
    tick(); checkWin4("h_held1", 0, 0, 20, 30, 40);
    applyStimulus(1, 8'd77, 0);
    #1;
    checkReady("h_ready2", bus4.ready_o, 1'b0);
    tick(); checkWin4("h_w3", 1, 1, 30, 40, 40);
    applyStimulus(0, 8'd0, 0);

    $display("[TB] reset mid-line");
    applyStimulus(1, 8'd10, 0); tick();
    applyStimulus(1, 8'd20, 0); tick(); checkWin4("r_w0", 1, 0, 10, 10, 20);
    applyStimulus(1, 8'd33, 0);
    rst_n = 1'b0;
    tick(); checkWin4("r_clear", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 8'd0, 0);
    #1;
    checkReady("r_ready", bus4.ready_o, 1'b1);
    applyStimulus(1, 8'd50, 0); tick(); checkWin4("r_x0", 0, 0, 0, 0, 0);
    applyStimulus(1, 8'd60, 0); tick(); checkWin4("r_w0b", 1, 0, 50, 50, 60);
    applyStimulus(1, 8'd70, 0); tick(); checkWin4("r_w1", 1, 0, 50, 60, 70);
    applyStimulus(1, 8'd80, 0); tick(); checkWin4("r_w2", 1, 0, 60, 70, 80);
    applyStimulus(0, 8'd0, 0); tick(); checkWin4("r_w3", 1, 1, 70, 80, 80);

    $display("[TB] LINE_LEN=2");
    applyStimulus2(1, 8'd7, 0); tick(); checkWin2("s_x0", 0, 0, 0, 0, 0);
    applyStimulus2(1, 8'd9, 0); tick(); checkWin2("s_w0", 1, 0, 7, 7, 9);
    checkReady("s_ready_flush", bus2.ready_o, 1'b0);
    applyStimulus2(0, 8'd0, 0); tick(); checkWin2("s_w1", 1, 1, 7, 9, 9);
    tick(); checkWin2("s_idle", 0, 0, 7, 9, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
